gcd_scheduler: RTL

Shares one subtractive GCD engine between N requesters. A round-robin arbiter grants one requester at a time and captures its operand pair. The block sequences the engine through load, run and completion, and presents a tagged result on a valid/ready output. Zero operands, which would make a subtractive engine spin forever, are resolved by the controller without running the engine.

---
 rtl/gcd_pkg.sv | 12 +
 rtl/gcd_engine.sv | 40 ++++
 rtl/gcd_scheduler.sv | 117 +++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared state encoding and default width for the GCD scheduler
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int GCD_WIDTH = 16;

endpackage

// File: rtl/gcd_engine.sv
// rtl/gcd_engine.sv - subtractive GCD datapath, one subtraction per cycle
module gcd_engine #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             init,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] o,
  output logic             fin
);

  logic [WIDTH-1:0] acc_a_q, acc_a_d;
  logic [WIDTH-1:0] acc_b_q, acc_b_d;

  assign fin = (acc_a_q == acc_b_q);
  assign o   = acc_a_q;

  // Larger minus smaller keeps both accumulators unsigned without underflow.
  always_comb begin
    acc_a_d = acc_a_q;
    acc_b_d = acc_b_q;
    if (init) begin
      acc_a_d = a;
      acc_b_d = b;
    end else if (!fin) begin
      if (acc_a_q > acc_b_q) begin
        acc_a_d = acc_a_q - acc_b_q;
      end else begin
        acc_b_d = acc_b_q - acc_a_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    acc_a_q <= acc_a_d;
    acc_b_q <= acc_b_d;
  end

endmodule

// File: rtl/gcd_scheduler.sv
// rtl/gcd_scheduler.sv - round-robin sharing of one GCD engine with tagged valid/ready results
module gcd_scheduler
  import gcd_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = GCD_WIDTH,
  parameter int IDW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] a_in,
  input  logic [N*WIDTH-1:0] b_in,
  output logic [N-1:0]       gnt,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   res_data,
  output logic [IDW-1:0]     res_id,
  output logic               busy
);

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]   win;
  logic [WIDTH-1:0] op_a, op_b;
  logic             eng_init;
  logic [WIDTH-1:0] eng_o;
  logic             eng_fin;

  function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] r, input logic [IDW-1:0] p);
    logic [IDW-1:0] w;
    logic           hit;
    int             idx;
    w   = '0;
    hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(p) + k;
      if (idx >= N) idx = idx - N;
      if (!hit && r[idx]) begin
        hit = 1'b1;
        w   = IDW'(idx);
      end
    end
    return w;
  endfunction

  assign win  = rr_pick(req, ptr_q);
  assign op_a = a_in[int'(win)*WIDTH +: WIDTH];
  assign op_b = b_in[int'(win)*WIDTH +: WIDTH];

  gcd_engine #(.WIDTH(WIDTH)) u_engine (
    .clk (clk),
    .init(eng_init),
    .a   (op_a),
    .b   (op_b),
    .o   (eng_o),
    .fin (eng_fin)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    data_d   = data_q;
    eng_init = 1'b0;
    gnt      = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt   = N'(1) << win;
          id_d  = win;
          ptr_d = (win == IDW'(N-1)) ? '0 : win + 1'b1;
          // A zero operand would never converge in the engine; resolve it here.
          if (op_a == '0 || op_b == '0) begin
            data_d  = op_a | op_b;
            state_d = DONE;
          end else begin
            eng_init = 1'b1;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        if (eng_fin) begin
          data_d  = eng_o;
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end

  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res_data  = data_q;
  assign res_id    = id_q;

endmodule
